uart_rx: RTL and testbench

UART receiver; the receive-side counterpart of the team's uart_tx, using the same frame format and parameter set. It oversamples the asynchronous serial line with the system clock and samples each bit at mid-period. Each received word is delivered as a single-cycle valid pulse, together with parity and framing error flags, to the downstream logic (register file or FIFO). There is no backpressure, because a UART cannot stall its sender.

---
 rtl/uart_rx.sv | 96 +++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, MSB first, optional parity, 1-2 stop bits
module uart_rx #(
    parameter int buad_rate       = 9600,
    parameter int clk_rate        = 50_000_000,
    parameter int uart_data_width = 8,
    parameter int check           = 1,
    parameter int stop_width      = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_rx,
    output logic [uart_data_width-1:0] o_rx_data,
    output logic                       o_rx_valid,
    output logic                       o_parity_err,
    output logic                       o_frame_err,
    output logic                       o_rx_busy
);
    localparam int BIT_DIV  = clk_rate / buad_rate;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int CW       = $clog2(BIT_DIV);
    localparam int NW       = $clog2(uart_data_width + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                     state;
    logic                       rx_m, rx_s, rx_d;
    logic [CW-1:0]              cnt;
    logic [NW-1:0]              n;
    logic [uart_data_width-1:0] shreg;
    logic                       par, perr, ferr, tick;

    assign tick      = cnt == CW'(HALF_DIV - 1);
    assign o_rx_busy = state != IDLE;

    // two-flop synchroniser on the async line, third flop delays it for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) {rx_m, rx_s, rx_d} <= 3'b111;
        else {rx_m, rx_s, rx_d} <= {i_rx, rx_m, rx_s};

    // receive FSM: samples every bit at mid-period and delivers the word with its error flags
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            n            <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            cnt        <= cnt == CW'(BIT_DIV - 1) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (rx_d && !rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (tick) begin
                    state <= rx_s ? IDLE : DATA;
                    n     <= '0;
                    par   <= 1'b0;
                    perr  <= 1'b0;
                    ferr  <= 1'b0;
                end
                DATA: if (tick) begin
                    shreg <= uart_data_width'({shreg, rx_s});
                    par   <= par ^ rx_s;
                    n     <= n + NW'(1);
                    if (n == NW'(uart_data_width - 1)) begin
                        n     <= '0;
                        state <= check > 0 ? PARITY : STOP;
                    end
                end
                PARITY: if (tick) begin
                    perr  <= rx_s != (check == 1 ? ~par : par);
                    state <= STOP;
                end
                STOP: if (tick) begin
                    n    <= n + NW'(1);
                    ferr <= ferr | ~rx_s;
                    if (n == NW'(stop_width - 1)) begin
                        state        <= IDLE;
                        o_rx_valid   <= 1'b1;
                        o_rx_data    <= shreg;
                        o_parity_err <= perr;
                        o_frame_err  <= ferr | ~rx_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames into odd- and even-parity receivers sharing one line
module tb_uart_rx;
    localparam int BD = 16;
    localparam int HD = 8;
    localparam int L  = 4 + 10 * BD + HD;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } rec_t;

    logic       i_clk = 0, i_rst_n = 0, i_rx = 1, clk_en = 1;
    logic [7:0] d1, d2;
    logic       v1, v2, pe1, pe2, fe1, fe2, b1, b2;
    rec_t       got1[$], got2[$], exp1[$], exp2[$];
    int         cyc = 0, checks = 0, errors = 0;

    uart_rx #(.buad_rate(1), .clk_rate(16), .uart_data_width(8), .check(1), .stop_width(1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .o_rx_data(d1), .o_rx_valid(v1),
        .o_parity_err(pe1), .o_frame_err(fe1), .o_rx_busy(b1));

    uart_rx #(.buad_rate(1), .clk_rate(16), .uart_data_width(8), .check(2), .stop_width(1)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .o_rx_data(d2), .o_rx_valid(v2),
        .o_parity_err(pe2), .o_frame_err(fe2), .o_rx_busy(b2));

    // gateable clock so reset can be checked with the clock stopped
    always begin
        #5;
        if (clk_en) i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // record every cycle in which a valid pulse is seen
    always @(negedge i_clk) begin
        if (v1) got1.push_back('{d1, pe1, fe1, cyc});
        if (v2) got2.push_back('{d2, pe2, fe2, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int cycles);
        @(negedge i_clk);
        i_rx = b;
        repeat (cycles - 1) @(negedge i_clk);
    endtask

    // one 11-bit frame; the model derives flags from the parity rule and stop level
    task automatic send(input logic [7:0] d, input logic pflip, input logic stop);
        logic p;
        int   t0;
        @(negedge i_clk);
        t0   = cyc;
        i_rx = 1'b0;
        repeat (BD - 1) @(negedge i_clk);
        for (int i = 7; i >= 0; i--) drive(d[i], BD);
        p = ~(^d) ^ pflip;
        drive(p, BD);
        drive(stop, BD);
        exp1.push_back('{d, (^{d, p}) != 1'b1, !stop, t0});
        exp2.push_back('{d, (^{d, p}) != 1'b0, !stop, t0});
        if (!stop) drive(1'b1, BD);
    endtask

    task automatic cmp_q(input string tag, input rec_t got[$], input rec_t exp[$]);
        int lat;
        chk($sformatf("%s_count", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s%0d_data", tag, i), got[i].d, exp[i].d);
            chk($sformatf("%s%0d_perr", tag, i), got[i].pe, exp[i].pe);
            chk($sformatf("%s%0d_ferr", tag, i), got[i].fe, exp[i].fe);
            lat = got[i].t - exp[i].t;
            checks++;
            assert (lat >= L - 1 && lat <= L + 1) else begin
                errors++;
                $error("FAIL %s%0d_latency observed %0d expected %0d+-1", tag, i, lat, L);
            end
        end
    endtask

    task automatic compare(input string tag);
        cmp_q({tag, "_odd"}, got1, exp1);
        cmp_q({tag, "_even"}, got2, exp2);
        got1.delete();
        got2.delete();
        exp1.delete();
        exp2.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data1"}, d1, 0);
        chk({tag, "_valid1"}, v1, 0);
        chk({tag, "_perr1"}, pe1, 0);
        chk({tag, "_ferr1"}, fe1, 0);
        chk({tag, "_busy1"}, b1, 0);
        chk({tag, "_data2"}, d2, 0);
        chk({tag, "_valid2"}, v2, 0);
        chk({tag, "_perr2"}, pe2, 0);
        chk({tag, "_ferr2"}, fe2, 0);
        chk({tag, "_busy2"}, b2, 0);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_rst_n = 1;
        drive(1'b1, 2 * BD);

        send(8'hA5, 1'b0, 1'b1);
        drive(1'b1, BD);
        compare("nominal");

        send(8'hA5, 1'b1, 1'b1);
        drive(1'b1, BD);
        compare("parflip");

        send(8'h5A, 1'b0, 1'b0);
        compare("framing");

        @(negedge i_clk);
        t0   = cyc;
        i_rx = 1'b0;
        repeat (30 * BD - 1) @(negedge i_clk);
        exp1.push_back('{8'h00, 1'b1, 1'b1, t0});
        exp2.push_back('{8'h00, 1'b0, 1'b1, t0});
        drive(1'b1, 2 * BD);
        compare("break");
        send(8'h81, 1'b0, 1'b1);
        drive(1'b1, BD);
        compare("after_break");

        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("glitch_busy_on", b1, 1);
        repeat (2) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (HD - 1) @(negedge i_clk);
        chk("glitch_busy_off1", b1, 0);
        chk("glitch_busy_off2", b2, 0);
        drive(1'b1, 2 * BD);
        compare("glitch");

        for (int i = 0; i < 12; i++)
            send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
        drive(1'b1, BD);
        compare("random");

        send(8'h00, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b1);
        drive(1'b1, BD);
        compare("b2b");

        drive(1'b0, BD);
        drive(1'b1, 3 * BD);
        chk("midframe_busy", b1, 1);
        clk_en = 0;
        #2 i_rst_n = 0;
        #1 chk_zero("async_reset");
        #2 i_rx = 1;
        i_rst_n = 1;
        clk_en  = 1;
        drive(1'b1, 2 * BD);
        send(8'hC3, 1'b0, 1'b1);
        drive(1'b1, BD);
        compare("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
